// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch PC controller: FSM encodings, PC defaults,
// and the PC incrementer used by the top level.
package fetch_pc_ctrl_pkg;

    localparam int          PC_W         = 16;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    localparam logic [15:0] DEF_PC_INC   = 16'd2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    // Generate/propagate adder with carry-in 0; wraps silently at 16 bits.
    function automatic logic [15:0] pc_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] c;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        for (int i = 0; i < 15; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return p ^ c;
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_pc_reg.sv
// PC storage: register with synchronous reset-to-value and write enable.
// One-cycle write latency; holds its value whenever we is low.
module fetch_pc_ctrl_pc_reg #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: next-PC arbitration (redirect > halt > stall > sequential),
// IMEM handshake with redirect drain, flush generation. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEF_RESET_PC,
    parameter logic [15:0] PC_INC   = DEF_PC_INC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        imem_done,
    input  logic        ex_redirect,
    input  logic [15:0] ex_target,
    input  logic        id_halt,
    output logic [15:0] fetch_pc,
    output logic        imem_rd,
    output logic        if_valid,
    output logic [15:0] if_pc_inc,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] redirect_cnt,
    output logic [15:0] fetch_cnt
`endif
);

    state_t      state;
    state_t      state_nxt;
    logic        in_halt;
    logic        redir;
    logic        halt_req;
    logic        seq_adv;
    logic        pc_we;
    logic [15:0] pc_d;

    assign in_halt  = (state == ST_HALTED);
    assign redir    = !rst && !in_halt && ex_redirect;
    assign halt_req = !rst && !in_halt && !ex_redirect && id_halt;
    assign seq_adv  = !rst && (state == ST_RUN) && imem_done && !ex_redirect && !id_halt && !stall;

    assign if_pc_inc   = pc_add(fetch_pc, PC_INC);
    assign imem_rd     = !rst && (state == ST_RUN);
    assign if_valid    = seq_adv;
    assign flush_if_id = redir | halt_req;
    assign flush_id_ex = redir;
    assign halted      = !rst && in_halt;

    assign pc_we = redir | seq_adv;
    assign pc_d  = redir ? (ex_target & 16'hFFFE) : if_pc_inc;

    fetch_pc_ctrl_pc_reg #(
        .WIDTH     (PC_W),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .we  (pc_we),
        .d   (pc_d),
        .q   (fetch_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A redirect with no response this cycle leaves a fetch in flight that must be dropped.
    // In DRAIN, a response coinciding with a new redirect retires the old fetch, so RUN resumes.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (ex_redirect) begin
                    state_nxt = imem_done ? ST_RUN : ST_DRAIN;
                end else if (id_halt) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_DRAIN: begin
                if (ex_redirect) begin
                    state_nxt = imem_done ? ST_RUN : ST_DRAIN;
                end else if (id_halt) begin
                    state_nxt = ST_HALTED;
                end else if (imem_done) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt <= '0;
            fetch_cnt    <= '0;
        end else if (!in_halt) begin
            if (ex_redirect && (redirect_cnt != 16'hFFFF)) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
            if (if_valid && (fetch_cnt != 16'hFFFF)) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: reset, sequential fetch, miss, redirect, drain,
// halt priority, wrap-around and stall. Counter checks follow FETCH_PERF_CNT_EN.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        imem_done;
    logic        ex_redirect;
    logic [15:0] ex_target;
    logic        id_halt;
    logic [15:0] fetch_pc;
    logic        imem_rd;
    logic        if_valid;
    logic [15:0] if_pc_inc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] redirect_cnt;
    logic [15:0] fetch_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .imem_done   (imem_done),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .id_halt     (id_halt),
        .fetch_pc    (fetch_pc),
        .imem_rd     (imem_rd),
        .if_valid    (if_valid),
        .if_pc_inc   (if_pc_inc),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .redirect_cnt (redirect_cnt),
        .fetch_cnt    (fetch_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; imem_done = 1'b1;
        ex_redirect = 1'b0; ex_target = 16'h0000; id_halt = 1'b0;

        // Test 1: reset then sequential fetch
        #1;
        chk("rst_imem_rd", 16'(imem_rd), 16'h0);
        chk("rst_if_valid", 16'(if_valid), 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);
        step();
        chk("rst_pc", fetch_pc, 16'h0000);
        step();
        rst = 1'b0;
        #1;
        chk("t1_pc0", fetch_pc, 16'h0000);
        chk("t1_imem_rd", 16'(imem_rd), 16'h1);
        chk("t1_valid0", 16'(if_valid), 16'h1);
        chk("t1_pc_inc", if_pc_inc, 16'h0002);
        step();
        chk("t1_pc2", fetch_pc, 16'h0002);
        chk("t1_valid1", 16'(if_valid), 16'h1);
        step();
        chk("t1_pc4", fetch_pc, 16'h0004);
        step();
        chk("t1_pc6", fetch_pc, 16'h0006);
        repeat (5) step();
        chk("t2_pc10", fetch_pc, 16'h0010);

        // Test 2: three-cycle miss at 0x0010
        imem_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_miss_valid", 16'(if_valid), 16'h0);
            chk("t2_miss_rd", 16'(imem_rd), 16'h1);
            step();
            chk("t2_miss_pc", fetch_pc, 16'h0010);
        end
        imem_done = 1'b1;
        #1;
        chk("t2_done_valid", 16'(if_valid), 16'h1);
        step();
        chk("t2_pc12", fetch_pc, 16'h0012);

        // Test 3: redirect on a hit, target LSB cleared
        ex_redirect = 1'b1; ex_target = 16'h0101;
        #1;
        chk("t3_flush_if_id", 16'(flush_if_id), 16'h1);
        chk("t3_flush_id_ex", 16'(flush_id_ex), 16'h1);
        chk("t3_valid", 16'(if_valid), 16'h0);
        step();
        ex_redirect = 1'b0;
        #1;
        chk("t3_pc", fetch_pc, 16'h0100);
        chk("t3_flush_clear", 16'(flush_if_id), 16'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("t3_redirect_cnt", redirect_cnt, 16'd1);
        chk("t3_fetch_cnt", fetch_cnt, 16'd9);
`endif

        // Test 4: redirect during a miss enters DRAIN
        imem_done = 1'b0; ex_redirect = 1'b1; ex_target = 16'h0200;
        #1;
        chk("t4_flush", 16'(flush_id_ex), 16'h1);
        step();
        ex_redirect = 1'b0;
        #1;
        chk("t4_drain_rd", 16'(imem_rd), 16'h0);
        chk("t4_drain_pc", fetch_pc, 16'h0200);
        chk("t4_drain_valid", 16'(if_valid), 16'h0);
        step();
        chk("t4_drain_rd2", 16'(imem_rd), 16'h0);
        imem_done = 1'b1;
        #1;
        chk("t4_done_valid", 16'(if_valid), 16'h0);
        step();
        chk("t4_run_rd", 16'(imem_rd), 16'h1);
        chk("t4_run_pc", fetch_pc, 16'h0200);
        step();
        chk("t4_pc202", fetch_pc, 16'h0202);

        // Test 5: redirect beats halt; then halt alone; then reset out of HALTED
        id_halt = 1'b1; ex_redirect = 1'b1; ex_target = 16'h0040;
        #1;
        chk("t5_both_flush_ex", 16'(flush_id_ex), 16'h1);
        step();
        id_halt = 1'b0; ex_redirect = 1'b0;
        #1;
        chk("t5_not_halted", 16'(halted), 16'h0);
        chk("t5_pc40", fetch_pc, 16'h0040);
        id_halt = 1'b1;
        #1;
        chk("t5_halt_flush_if", 16'(flush_if_id), 16'h1);
        chk("t5_halt_flush_ex", 16'(flush_id_ex), 16'h0);
        chk("t5_halt_valid", 16'(if_valid), 16'h0);
        step();
        id_halt = 1'b0;
        #1;
        chk("t5_halted", 16'(halted), 16'h1);
        chk("t5_halt_rd", 16'(imem_rd), 16'h0);
        ex_redirect = 1'b1; ex_target = 16'h0080;
        #1;
        chk("t5_halt_no_flush", 16'(flush_if_id), 16'h0);
        step();
        ex_redirect = 1'b0;
        #1;
        chk("t5_halted_held", 16'(halted), 16'h1);
        chk("t5_halt_pc", fetch_pc, 16'h0040);
`ifdef FETCH_PERF_CNT_EN
        chk("t5_redirect_cnt", redirect_cnt, 16'd3);
        chk("t5_fetch_cnt", fetch_cnt, 16'd10);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_rst_pc", fetch_pc, 16'h0000);
        chk("t5_rst_halted", 16'(halted), 16'h0);
        chk("t5_rst_rd", 16'(imem_rd), 16'h1);
`ifdef FETCH_PERF_CNT_EN
        chk("t5_rst_cnt", redirect_cnt, 16'd0);
`endif

        // Test 6: wrap-around from 0xFFFE
        ex_redirect = 1'b1; ex_target = 16'hFFFF;
        step();
        ex_redirect = 1'b0;
        #1;
        chk("t6_pc_fffe", fetch_pc, 16'hFFFE);
        chk("t6_pc_inc_wrap", if_pc_inc, 16'h0000);
        step();
        chk("t6_pc_wrap", fetch_pc, 16'h0000);

        // Stall with a hit holds the PC and suppresses if_valid
        stall = 1'b1;
        #1;
        chk("st_valid", 16'(if_valid), 16'h0);
        step();
        chk("st_pc_held", fetch_pc, 16'h0000);
        stall = 1'b0;
        step();
        chk("st_pc_adv", fetch_pc, 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
